pe_mem_sched: RTL and testbench
===============================

Name: pe_mem_sched

Overview:
- Round-robin scheduler that shares one PE weight memory among N_REQ requesters.
- The memory is a synchronous-read array: address is sampled at clk, and data appears on the memory's registered output one cycle later.
- Each requester asks for a burst of consecutive words from a base address. The block sequences the addresses, then returns the data tagged with the requester id, plus a per-requester done pulse.
- Sits between the PE array's load logic and the weight memory.

Parameters:
- WORD_WIDTH, 16, memory word width.
- ADDR_WIDTH, 4, memory address width; RAM_DEPTH = 2**ADDR_WIDTH.
- N_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of the requester id; must satisfy 2**ID_WIDTH >= N_REQ.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester burst request; level, held high until done.
- req_base  input  N_REQ*ADDR_WIDTH  packed base addresses; slice i belongs to requester i.
- req_len  input  N_REQ*ADDR_WIDTH  packed burst length minus 1; 0 means 1 word, all-ones means RAM_DEPTH words.
- mem_addr  output  ADDR_WIDTH  address to the memory.
- mem_rdata  input  WORD_WIDTH  registered memory output.
- rdata  output  WORD_WIDTH  returned word; wired directly from mem_rdata.
- rdata_valid  output  1  rdata holds a word of the current burst.
- rdata_id  output  ID_WIDTH  requester that owns rdata.
- done  output  N_REQ  one-cycle pulse on the granted requester's bit, coincident with its last valid word.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state IDLE, mem_addr 0, rdata_valid 0, rdata_id 0, done 0, busy 0. The round-robin pointer resets to N_REQ-1, so requester 0 wins first.
- States: IDLE, BURST, DRAIN.
- IDLE, any req bit high:
  - Select the winner by scanning upward from pointer+1, modulo N_REQ.
  - Latch grant_id, addr_cnt = req_base[grant], remain = req_len[grant].
  - Update pointer to grant_id, then go to BURST.
- IDLE, no req bit high: stay in IDLE.
- BURST, every cycle:
  - mem_addr = addr_cnt; addr_cnt increments modulo RAM_DEPTH (wraps 15 -> 0).
  - If remain == 0, go to DRAIN; otherwise decrement remain.
- DRAIN: lasts exactly one cycle, then returns to IDLE.
- Read path:
  - rdata_valid is registered and equals "state was BURST in the previous cycle".
  - rdata_id is the registered grant_id.
  - done[grant_id] is asserted in the DRAIN cycle.
- Latency: req sampled high at edge k -> first address presented in cycle k+1 -> first valid word in cycle k+2. An L-word burst has valid words in cycles k+2 .. k+L+1.
- Arbitration happens only in IDLE, so there is a one-cycle IDLE bubble between bursts.
- Maximum throughput: L words per L+2 cycles.
- Deasserting req mid-burst is ignored; the burst completes in full.
- Changing req_base or req_len after grant has no effect, because both are latched.
- Requests that arrive during BURST or DRAIN wait for the next IDLE.
- Re-request: a requester holding req through its done pulse is re-arbitrated in the following IDLE cycle, behind any other pending requester.
- Reset mid-burst: the burst is aborted immediately and all outputs return to their reset values. No done pulse is issued for the aborted burst.
- mem_addr holds its last value in IDLE and DRAIN; the memory read it causes is discarded because rdata_valid is 0.

Optional Feature:
- Macro: PE_MEM_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest-index requesting bit always wins. The pointer register is not built.
- Undefined (default): round-robin as described above.

Decomposition:
- Shared package pe_mem_pkg:
  - state encoding localparams: IDLE=2'd0, BURST=2'd1, DRAIN=2'd2.
  - default WORD_WIDTH / ADDR_WIDTH constants shared with the memory.
- One natural sub-module, rr_arbiter:
  - inputs: req, pointer.
  - outputs: one-hot grant and binary grant_id.
  - combinational; the fixed-priority macro lives inside it.

Test Plan:
- Single burst: req=0001, base0=3, len0=3 (4 words), memory preloaded with mem[a]=a+100. Expect:
  - mem_addr 3,4,5,6 in cycles 1-4.
  - rdata 103,104,105,106 with valid, rdata_id=0, in cycles 2-5.
  - done=0001 in cycle 5.
- Wrap-around: base=14, len=3. Expect mem_addr 14,15,0,1 and rdata 114,115,100,101.
- Round-robin: req=1111 held, all len=0. Expect grant order 0,1,2,3,0, with one word each and a 3-cycle period per grant.
- Late request: req1 rises while requester 0 is in BURST. Expect requester 1 to be granted only in the IDLE cycle after done[0], with no overlap of rdata_id.
- Reset mid-burst: assert rst on the 2nd BURST cycle of a len=7 burst. Expect:
  - outputs 0 immediately, no done pulse.
  - after release, the pending req is re-granted starting at its base.
- With PE_MEM_SCHED_FIXED_PRIO_EN defined: req=0110 held. Expect requester 1 to be granted every time and requester 2 never.

Source files
------------

// File: rtl/pe_mem_pkg.sv
// Shared constants for the PE weight-memory scheduler: state encoding and the
// default memory geometry also used by the weight memory itself.
package pe_mem_pkg;

  localparam int PE_WORD_WIDTH = 16;
  localparam int PE_ADDR_WIDTH = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Requester index reached by stepping 'offset' places past 'ptr' in a ring of n.
  function automatic int rr_index(input int ptr, input int offset, input int n);
    return (ptr + offset) % n;
  endfunction

endpackage

// File: rtl/pe_mem_sched_rr_arbiter.sv
// Combinational requester arbiter: round-robin from pointer+1 by default, or
// lowest-index-wins when PE_MEM_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter
  import pe_mem_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] pointer,
  output logic [N_REQ-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_id
);

  logic w_found;
`ifndef PE_MEM_SCHED_FIXED_PRIO_EN
  int   w_idx;
`endif

  // Winner selection; the first requesting bit in scan order takes the grant.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
`ifdef PE_MEM_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[i]) begin
        grant[i] = 1'b1;
        grant_id = ID_WIDTH'(i);
        w_found  = 1'b1;
      end else begin
        w_found  = w_found;
      end
    end
`else
    w_idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = rr_index(int'(pointer), k, N_REQ);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_id     = ID_WIDTH'(w_idx);
        w_found      = 1'b1;
      end else begin
        w_found      = w_found;
      end
    end
`endif
  end

endmodule

// File: rtl/pe_mem_sched.sv
// Burst scheduler sharing one synchronous-read weight memory among N_REQ requesters.
// Optional build macro: PE_MEM_SCHED_FIXED_PRIO_EN (fixed priority, no pointer register).
module pe_mem_sched
  import pe_mem_pkg::*;
#(
  parameter int WORD_WIDTH = PE_WORD_WIDTH,
  parameter int ADDR_WIDTH = PE_ADDR_WIDTH,
  parameter int N_REQ      = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_base,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_len,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic [WORD_WIDTH-1:0]       mem_rdata,
  output logic [WORD_WIDTH-1:0]       rdata,
  output logic                        rdata_valid,
  output logic [ID_WIDTH-1:0]         rdata_id,
  output logic [N_REQ-1:0]            done,
  output logic                        busy
);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr_cnt;
  logic [ADDR_WIDTH-1:0] r_remain;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [N_REQ-1:0]      r_grant_oh;
  logic                  r_busy;
  logic                  r_valid;
  logic [ID_WIDTH-1:0]   r_rdata_id;
  logic [N_REQ-1:0]      r_done;

  logic [N_REQ-1:0]      w_grant;
  logic [ID_WIDTH-1:0]   w_grant_id;
  logic [ID_WIDTH-1:0]   w_ptr;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_len;
  logic                  w_start;

  assign w_start = (r_state == IDLE) && (|req);
  assign w_base  = req_base[int'(w_grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_len   = req_len[int'(w_grant_id)*ADDR_WIDTH +: ADDR_WIDTH];

  rr_arbiter #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req      (req),
    .pointer  (w_ptr),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );

`ifdef PE_MEM_SCHED_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [ID_WIDTH-1:0] r_ptr;

  // Round-robin pointer: last granted requester, so requester 0 wins first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= ID_WIDTH'(N_REQ - 1);
    end else if (w_start) begin
      r_ptr <= w_grant_id;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Burst sequencer; the address register is the memory address, held outside BURST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr_cnt <= '0;
      r_remain   <= '0;
      r_grant_id <= '0;
      r_grant_oh <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= BURST;
            r_addr_cnt <= w_base;
            r_remain   <= w_len;
            r_grant_id <= w_grant_id;
            r_grant_oh <= w_grant;
            r_busy     <= 1'b1;
          end else begin
            r_busy     <= 1'b0;
          end
        end
        BURST: begin
          if (r_remain == '0) begin
            r_state    <= DRAIN;
          end else begin
            r_remain   <= r_remain - ADDR_WIDTH'(1);
            r_addr_cnt <= r_addr_cnt + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read-return tagging, one cycle behind the address the memory sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_rdata_id <= '0;
      r_done     <= '0;
    end else begin
      r_valid    <= (r_state == BURST);
      r_rdata_id <= r_grant_id;
      if ((r_state == BURST) && (r_remain == '0)) begin
        r_done <= r_grant_oh;
      end else begin
        r_done <= '0;
      end
    end
  end

  assign mem_addr    = r_addr_cnt;
  assign rdata       = mem_rdata;
  assign rdata_valid = r_valid;
  assign rdata_id    = r_rdata_id;
  assign done        = r_done;
  assign busy        = r_busy;

endmodule

// File: tb/tb_pe_mem_sched.sv
// Self-checking bench for pe_mem_sched: directed scenarios plus random traffic,
// all checked against a transaction-level timeline model of grants and bursts.
module tb_pe_mem_sched;

  localparam int WW    = 16;
  localparam int AW    = 4;
  localparam int NR    = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 16;
  localparam int MAXC  = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_base;
  logic [NR*AW-1:0] req_len;
  logic [AW-1:0]    mem_addr;
  logic [WW-1:0]    mem_rdata;
  logic [WW-1:0]    rdata;
  logic             rdata_valid;
  logic [IW-1:0]    rdata_id;
  logic [NR-1:0]    done;
  logic             busy;

  pe_mem_sched #(
    .WORD_WIDTH (WW),
    .ADDR_WIDTH (AW),
    .N_REQ      (NR),
    .ID_WIDTH   (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_base    (req_base),
    .req_len     (req_len),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .rdata_id    (rdata_id),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [DEPTH];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  // Expected per-cycle observations, filled in whenever the model grants a burst.
  bit            e_busy  [MAXC];
  bit            e_valid [MAXC];
  bit            e_achk  [MAXC];
  logic [AW-1:0] e_addr  [MAXC];
  logic [WW-1:0] e_data  [MAXC];
  int            e_id    [MAXC];
  logic [NR-1:0] e_done  [MAXC];

  int cyc;
  int next_free;
  int m_ptr;
  int busy_until [NR];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r);
`ifdef PE_MEM_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NR; k++) if (r[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
`endif
    return -1;
  endfunction

  task automatic set_rq(input int i, input int b, input int l);
    req_base[i*AW +: AW] = AW'(b);
    req_len[i*AW +: AW]  = AW'(l);
  endtask

  task automatic reset_model();
    for (int c = cyc; c < cyc + 64; c++) begin
      e_busy[c] = 1'b0; e_valid[c] = 1'b0; e_achk[c] = 1'b0;
      e_done[c] = '0;   e_id[c] = 0;       e_addr[c] = '0;
    end
    next_free = cyc;
    m_ptr     = NR - 1;
    for (int i = 0; i < NR; i++) busy_until[i] = -10;
  endtask

  // Decide what happens in cycle 'cyc' given the requests visible at its closing edge.
  task automatic model_step();
    int g, b, len;
    if (cyc == next_free) begin
      if (req != '0) begin
        g   = pick(req);
        b   = int'(req_base[g*AW +: AW]);
        len = int'(req_len[g*AW +: AW]) + 1;
        for (int j = 0; j < len; j++) begin
          e_addr[cyc+1+j]  = AW'((b + j) % DEPTH);
          e_achk[cyc+1+j]  = 1'b1;
          e_valid[cyc+2+j] = 1'b1;
          e_data[cyc+2+j]  = mem[(b + j) % DEPTH];
          e_id[cyc+2+j]    = g;
        end
        e_addr[cyc+len+1] = AW'((b + len - 1) % DEPTH);
        e_achk[cyc+len+1] = 1'b1;
        e_addr[cyc+len+2] = AW'((b + len - 1) % DEPTH);
        e_achk[cyc+len+2] = 1'b1;
        for (int j = 1; j <= len + 1; j++) e_busy[cyc+j] = 1'b1;
        e_done[cyc+len+1]    = '0;
        e_done[cyc+len+1][g] = 1'b1;
        busy_until[g] = cyc + len + 1;
        next_free     = cyc + len + 2;
        m_ptr         = g;
      end else begin
        next_free = cyc + 1;
      end
    end
  endtask

  task automatic check_cycle();
    chk("busy", 32'(busy), 32'(e_busy[cyc]));
    chk("rdata_valid", 32'(rdata_valid), 32'(e_valid[cyc]));
    chk("done", 32'(done), 32'(e_done[cyc]));
    if (e_valid[cyc]) begin
      chk("rdata", 32'(rdata), 32'(e_data[cyc]));
      chk("rdata_id", 32'(rdata_id), e_id[cyc]);
    end
    if (e_achk[cyc]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
  endtask

  task automatic next_cycle();
    model_step();
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) next_cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(rdata_valid), 32'd0);
    chk({tag, "_id"},    32'(rdata_id), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  function automatic int rand_len();
    return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
  endfunction

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = WW'(a + 100);
    for (int c = 0; c < MAXC; c++) begin
      e_addr[c] = '0; e_data[c] = '0; e_done[c] = '0; e_id[c] = 0;
    end
    rst = 1'b1; req = '0; req_base = '0; req_len = '0;
    cyc = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    reset_model();
    check_cycle();

    // Single 4-word burst from base 3.
    set_rq(0, 3, 3); req = 4'b0001;
    run(5);
    chk("single_last_word", 32'(rdata), 32'd106);
    chk("single_done", 32'(done), 32'b0001);
    req = '0; run(10);

    // Burst wrapping 15 -> 0.
    set_rq(0, 14, 3); req = 4'b0001;
    run(5);
    chk("wrap_last_word", 32'(rdata), 32'd101);
    req = '0; run(10);

    // All requesters held, one word each.
    for (int i = 0; i < NR; i++) set_rq(i, 4 * i, 0);
    req = 4'b1111; run(15);
    req = '0; run(10);

    // Requester 1 arrives while requester 0 is mid-burst.
    set_rq(0, 0, 5); req = 4'b0001; run(2);
    set_rq(1, 8, 1); req = 4'b0011; run(5);
    req = 4'b0010; run(6);
    req = '0; run(10);

    // Reset on the second BURST cycle of an 8-word burst.
    set_rq(2, 5, 7); req = 4'b0100; run(2);
    rst = 1'b1; #1;
    chk_zero("rst_mid");
    @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b0;
    cyc++;
    reset_model();
    check_cycle();
    next_cycle();
    chk("rst_regrant_addr", 32'(mem_addr), 32'd5);
    run(9);
    req = '0; run(10);

    // Two requesters held together (fixed-priority build starves requester 2).
    set_rq(1, 1, 0); set_rq(2, 2, 0); req = 4'b0110;
    run(18);
    req = '0; run(10);

    // Random traffic with mid-burst drops, post-grant field changes and re-requests.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (cyc <= busy_until[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
          if ($urandom_range(0, 3) == 0) set_rq(i, $urandom_range(0, 15), rand_len());
        end else if (cyc == busy_until[i] + 1 && req[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_rq(i, $urandom_range(0, 15), rand_len());
            req[i] = 1'b1;
          end
        end
      end
      next_cycle();
    end
    req = '0; run(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
